// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, FSM states and opcode-class helper for seq_alu.
// Honours SEQ_ALU_DIV_EN: when undefined, DIVU/REMU are not iterative (they decode as illegal).
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_SLT   = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_AND   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        case (op_e'(op))
            OP_MUL, OP_MULHU: return 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU, OP_REMU: return 1'b1;
`endif
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unit: shift-add multiply (MUL_STEP bits/cycle) and, with SEQ_ALU_DIV_EN, restoring divide (1 bit/cycle).
// Operands latched on start_i; done_o marks the final iteration cycle with result_o valid that cycle; no backpressure.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic                 hi_q;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        last_cnt;

`ifdef SEQ_ALU_DIV_EN
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    logic                 is_div_q, is_rem_q;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q;
    logic [WIDTH:0]       rem_sh;
`endif

    always_comb begin
        prod_d = prod_q;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier_q[k]) prod_d = prod_d + (mcand_q << k);
        end
        last_cnt = MUL_LAST;
        result_o = hi_q ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
        // Divide-by-zero falls out naturally: every trial subtract succeeds, giving all-ones and the dividend.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        quo_d  = {quo_q[WIDTH-2:0], 1'b0};
        rem_d  = rem_sh[WIDTH-1:0];
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d    = WIDTH'(rem_sh - {1'b0, dvs_q});
            quo_d[0] = 1'b1;
        end
        if (is_div_q) begin
            last_cnt = DIV_LAST;
            result_o = is_rem_q ? rem_d : quo_d;
        end
`endif
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == last_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
`endif
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            hi_q     <= (op_i == OP_MULHU);
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= (op_i == OP_DIVU) || (op_i == OP_REMU);
            is_rem_q <= (op_i == OP_REMU);
            rem_q    <= '0;
            quo_q    <= a_i;
            dvs_q    <= b_i;
`endif
        end else if (busy_q) begin
            cnt_q    <= cnt_q + 1'b1;
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
`ifdef SEQ_ALU_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
`endif
            if (done_o) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete one cycle after accept, MUL/MULHU (and DIVU/REMU with SEQ_ALU_DIV_EN) iterate.
// Accepts only in IDLE; result held in DONE until out_ready, outputs zero whenever out_valid is low.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, illegal_q, out_valid_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic [SHW-1:0]   shamt;
    logic             accept, iter_op;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_result;

    assign shamt    = src_b[SHW-1:0];
    assign in_ready = (state_q == ST_IDLE) && !md_busy;
    assign accept   = in_valid && in_ready;
    assign iter_op  = is_iter_op(op);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_e'(op))
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            default: alu_ill = 1'b1;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept && iter_op),
        .op_i     (op),
        .a_i      (src_a),
        .b_i      (src_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Outputs are only loaded on entry to DONE and cleared on leaving it, so they read zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (iter_op) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            illegal_q   <= alu_ill;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_result;
                        zero_q      <= (md_result == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        result_q    <= '0;
                        zero_q      <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32, MUL_STEP=1); expectations follow SEQ_ALU_DIV_EN if defined.
module tb_seq_alu;
    localparam int W = 32;

    logic          clk, rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  src_a, src_b;
    logic [3:0]    op;
    logic          out_valid, out_ready;
    logic [W-1:0]  result;
    logic          zero, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    // Reference behaviour computed from the operation definitions with plain arithmetic.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
        logic [63:0] p;
        int          sh;
        sh  = int'(b % 32);
        p   = 64'(a) * 64'(b);
        r   = 32'd0;
        il  = 1'b0;
        lat = 0;
        case (o)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0111: r = a & b;
            4'b0011: r = a | b;
            4'b0010: r = a ^ b;
            4'b0101: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'b0110: r = a << sh;
            4'b1000: r = a >> sh;
            4'b1001: r = a[31] ? ~((~a) >> sh) : (a >> sh);
            4'b1010: begin r = p[31:0];  lat = 32; end
            4'b1011: begin r = p[63:32]; lat = 32; end
`ifdef SEQ_ALU_DIV_EN
            4'b1100: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 32; end
            4'b1101: begin r = (b == 0) ? a : a % b;             lat = 32; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Issues one request from a negedge in IDLE and returns what the DUT produced; leaves the DUT in IDLE.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic il, output int lat,
                          output logic rdy_seen, output logic leak, output logic tmo);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 4'($urandom_range(0, 15));
        lat = 0; rdy_seen = 1'b0; leak = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            if (result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0) leak = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        tmo = !out_valid;
        r = result; z = zero; il = illegal;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; src_a = '0; src_b = '0; op = '0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b need 0", out_valid); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid_rel: got %b need 0", out_valid); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL reset_result: got %h need 0", result); else n_pass++;
        n_checks++; if (zero !== 1'b0 || illegal !== 1'b0)
            $display("FAIL reset_flags: got zero=%b illegal=%b need 0/0", zero, illegal); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] r; logic z, il, rs, lk, to; int lat;
        run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd0 || z !== 1'b1) $display("FAIL add_wrap: got %h zero=%b need 0 zero=1", r, z); else n_pass++;
        n_checks++; if (lat !== 0 || to) $display("FAIL add_latency: got %0d extra cycles need 0", lat); else n_pass++;
        run_op(4'b0100, 32'hFFFF_FFFF, 32'd1, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd1) $display("FAIL slt_neg: got %h need 1", r); else n_pass++;
        run_op(4'b0101, 32'hFFFF_FFFF, 32'd1, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd0 || z !== 1'b1) $display("FAIL sltu: got %h zero=%b need 0 zero=1", r, z); else n_pass++;
        run_op(4'b1001, 32'h8000_0000, 32'h3F, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL sra_31: got %h need ffffffff", r); else n_pass++;
        run_op(4'b1010, 32'h1_0000, 32'h1_0000, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd0 || z !== 1'b1) $display("FAIL mul_low: got %h zero=%b need 0 zero=1", r, z); else n_pass++;
        n_checks++; if (lat !== 32 || to) $display("FAIL mul_busy_cycles: got %0d need 32", lat); else n_pass++;
        n_checks++; if (rs !== 1'b0) $display("FAIL mul_in_ready: got in_ready high while busy, need low"); else n_pass++;
        run_op(4'b1011, 32'h1_0000, 32'h1_0000, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd1) $display("FAIL mulhu: got %h need 1", r); else n_pass++;
        run_op(4'b1100, 32'd7, 32'd0, r, z, il, lat, rs, lk, to);
`ifdef SEQ_ALU_DIV_EN
        n_checks++; if (r !== 32'hFFFF_FFFF || il !== 1'b0 || lat !== 32)
            $display("FAIL divu_by0: got %h ill=%b lat=%0d need ffffffff 0 32", r, il, lat); else n_pass++;
`else
        n_checks++; if (r !== 32'd0 || il !== 1'b1 || z !== 1'b1 || lat !== 0)
            $display("FAIL divu_disabled: got %h ill=%b zero=%b lat=%0d need 0 1 1 0", r, il, z, lat); else n_pass++;
`endif
        run_op(4'b1101, 32'd7, 32'd0, r, z, il, lat, rs, lk, to);
`ifdef SEQ_ALU_DIV_EN
        n_checks++; if (r !== 32'd7 || il !== 1'b0 || lat !== 32)
            $display("FAIL remu_by0: got %h ill=%b lat=%0d need 7 0 32", r, il, lat); else n_pass++;
`else
        n_checks++; if (r !== 32'd0 || il !== 1'b1 || lat !== 0)
            $display("FAIL remu_disabled: got %h ill=%b lat=%0d need 0 1 0", r, il, lat); else n_pass++;
`endif
        run_op(4'b1111, 32'h1234, 32'h5678, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd0 || z !== 1'b1 || il !== 1'b1 || lat !== 0)
            $display("FAIL illegal_op: got %h zero=%b ill=%b lat=%0d need 0 1 1 0", r, z, il, lat); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, er; logic z, il, eil, rs, lk, to; int lat, elat;
        logic [3:0] o;
        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            n_checks++; if (in_ready !== 1'b1) $display("FAIL rnd_ready[%0d]: got %b need 1", i, in_ready); else n_pass++;
            model(o, a, b, er, eil, elat);
            run_op(o, a, b, r, z, il, lat, rs, lk, to);
            n_checks++; if (r !== er || z !== (er == 32'd0) || il !== eil)
                $display("FAIL rnd_result[%0d] op=%h a=%h b=%h: got %h z=%b il=%b need %h z=%b il=%b",
                         i, o, a, b, r, z, il, er, (er == 32'd0), eil); else n_pass++;
            n_checks++; if (lat !== elat || to) $display("FAIL rnd_latency[%0d] op=%h: got %0d need %0d", i, o, lat, elat); else n_pass++;
            n_checks++; if (lk !== 1'b0 || rs !== 1'b0)
                $display("FAIL rnd_idle_outputs[%0d]: got leak=%b ready_seen=%b need 0/0", i, lk, rs); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int wait_n;
        op = 4'b0000; src_a = 32'd40; src_b = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        src_a = 32'd9; src_b = 32'd9; op = 4'b0001;
        wait_n = 0;
        while (!out_valid && wait_n < 50) begin @(negedge clk); wait_n++; end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (out_valid !== 1'b1 || result !== 32'd42 || zero !== 1'b0 || illegal !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%b %h z=%b il=%b need 1 0000002a 0 0", c, out_valid, result, zero, illegal); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b need 0", c, in_ready); else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0)
            $display("FAIL bp_release: got v=%b rdy=%b res=%h need 0 1 0", out_valid, in_ready, result); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_reaccept: got out_valid %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midbusy();
        logic [31:0] r; logic z, il, rs, lk, to; int lat; logic seen;
        op = 4'b1010; src_a = 32'd123; src_b = 32'd456; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_busy_async: got v=%b rdy=%b need 0 1", out_valid, in_ready); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_busy_no_result: got out_valid after reset, need none"); else n_pass++;
        run_op(4'b0000, 32'd2, 32'd3, r, z, il, lat, rs, lk, to);
        n_checks++; if (r !== 32'd5 || z !== 1'b0 || il !== 1'b0 || lat !== 0)
            $display("FAIL rst_busy_next_add: got %h z=%b il=%b lat=%0d need 5 0 0 0", r, z, il, lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midbusy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, power of two).
REQ-002 SHALL have parameter MUL_STEP, default 1, product bits retired per iterative cycle (1, 2 or 4; divides WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have ports src_a, src_b  input  WIDTH  operands; port op  input  4  operation code.
REQ-008 SHALL have port out_valid  output  1  result held.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports result  output  WIDTH; zero  output  1 (result==0); illegal  output  1 (unsupported op).

Function
REQ-011 SHALL encode op: 0000 ADD, 0001 SUB, 0111 AND, 0011 OR, 0101 SLTU, 0010 XOR, 0100 SLT (signed), 0110 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH), 1011 MULHU, 1100 DIVU, 1101 REMU; others illegal.
REQ-012 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept on in_valid&&in_ready; src_a/src_b/op latched at acceptance.
REQ-014 SHALL complete single-cycle ops (ADD..SRA, illegal): IDLE->DONE, out_valid high the cycle after acceptance.
REQ-015 SHALL complete MUL/MULHU/DIVU/REMU via IDLE->BUSY, iterating exactly WIDTH/MUL_STEP cycles (divide: WIDTH cycles, 1 bit/cycle), then BUSY->DONE.
REQ-016 SHALL hold result, zero, illegal stable in DONE until out_valid&&out_ready, then return to IDLE; no new acceptance in the same cycle.
REQ-017 SHALL drive result/zero/illegal to 0 when out_valid is low.
REQ-018 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH; no overflow flag.
REQ-019 SHALL use src_b[log2(WIDTH)-1:0] as shift amount; higher bits ignored.
REQ-020 SHALL produce SLT/SLTU result 1 or 0 zero-extended to WIDTH.
REQ-021 SHALL return all-ones for DIVU by zero and src_a for REMU by zero, with normal latency.
REQ-022 SHALL treat illegal op: result 0, zero 1, illegal 1, single-cycle latency.
REQ-023 SHALL ignore in_valid and input changes while BUSY or DONE.

Reset
REQ-024 SHALL on rst, immediately and asynchronously, enter IDLE, clear iteration counter and partial results; out_valid 0, result 0, zero 0, illegal 0, in_ready 1 after release.
REQ-025 SHALL abandon any in-flight operation when rst asserts mid-BUSY or mid-DONE; no result emitted.

Configuration
REQ-026 SHALL support macro SEQ_ALU_DIV_EN: defined -> DIVU/REMU implemented per REQ-015/021.
REQ-027 SHALL, without SEQ_ALU_DIV_EN, treat 1100/1101 as illegal per REQ-022 and synthesise no divider logic.

Structure
REQ-028 SHALL place op encodings (enum), FSM state typedef and opcode-class helper in package seq_alu_pkg.
REQ-029 SHALL implement iterative multiply/divide in one sub-module seq_alu_muldiv (start/busy/done, WIDTH parameter); single-cycle datapath stays in seq_alu.

Verification
REQ-030 Bench SHALL cover: WIDTH=32, ADD 0xFFFFFFFF+1 -> result 0, zero 1, out_valid one cycle after accept.
REQ-031 Bench SHALL cover: SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 31 (src_b=0x3F) -> 0xFFFFFFFF.
REQ-032 Bench SHALL cover: MUL 0x10000 x 0x10000 MUL_STEP=1 -> 0 after 32 BUSY cycles; MULHU same -> 0x1; in_ready low throughout.
REQ-033 Bench SHALL cover: SEQ_ALU_DIV_EN defined, DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7; undefined -> illegal 1, result 0.
REQ-034 Bench SHALL cover: out_ready held low 5 cycles in DONE -> result stable, in_ready low; release -> IDLE next cycle.
REQ-035 Bench SHALL cover: rst asserted at BUSY cycle 10 -> out_valid 0 immediately, no result after release, next ADD 2+3 -> 5.
